// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter slice.
// Holds the 640x480@60 timing constants, the default frame-buffer geometry,
// the bus widths, the pixel type and the CPU-port FSM state enum.
package vga_fb_pkg;

    // Horizontal timing: active / front porch / sync / back porch
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing: active / front porch / sync / back porch
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 29;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Frame-buffer geometry: one stored pixel covers 2^FB_SCALE x 2^FB_SCALE
    localparam int unsigned FB_SCALE  = 2;
    localparam int unsigned FB_WIDTH  = H_ACTIVE >> FB_SCALE;
    localparam int unsigned FB_HEIGHT = V_ACTIVE >> FB_SCALE;

    localparam int unsigned FB_AW = 15;
    localparam int unsigned FB_DW = 12;

    typedef logic [FB_DW-1:0] pixel_t;

    typedef enum logic {
        CPU_IDLE = 1'b0,
        CPU_ACK  = 1'b1
    } cpu_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// CPU access port of the frame-buffer arbiter.
//   reqCpu  : request, held until ackCpu
//   weCpu   : 1 = write, 0 = read
//   adrCpu  : word address
//   datCpuW : write data
//   ackCpu  : one-cycle completion pulse
//   datCpuR : read data, valid while ackCpu is high
// master = CPU side, slave = arbiter side.
interface vga_fb_arbiter_if
    import vga_fb_pkg::*;
#(
    parameter int unsigned AW = FB_AW,
    parameter int unsigned DW = FB_DW
) ();

    logic          reqCpu;
    logic          weCpu;
    logic [AW-1:0] adrCpu;
    logic [DW-1:0] datCpuW;
    logic          ackCpu;
    logic [DW-1:0] datCpuR;

    modport master (
        output reqCpu, weCpu, adrCpu, datCpuW,
        input  ackCpu, datCpuR
    );

    modport slave (
        input  reqCpu, weCpu, adrCpu, datCpuW,
        output ackCpu, datCpuR
    );

endinterface

// File: rtl/vga_fb_addr_gen.sv
// Display-slot detection and frame-buffer address for the current scan position.
//   adr_hor, adr_ver : screen coordinates from the timing generator
//   active           : active-video flag
//   slot             : this cycle belongs to the display (first column of a pixel block)
//   slot_adr         : (adr_ver >> SCALE) * FB_W + (adr_hor >> SCALE), AW bits
module vga_fb_addr_gen
    import vga_fb_pkg::*;
#(
    parameter int unsigned SCALE = FB_SCALE,
    parameter int unsigned FB_W  = FB_WIDTH,
    parameter int unsigned AW    = FB_AW
) (
    input  logic [9:0]    adr_hor,
    input  logic [9:0]    adr_ver,
    input  logic          active,
    output logic          slot,
    output logic [AW-1:0] slot_adr
);

    logic [AW-1:0] col;
    logic [AW-1:0] row;

    always_comb begin
        col      = AW'(adr_hor >> SCALE);
        row      = AW'(adr_ver >> SCALE);
        slot_adr = row * AW'(FB_W) + col;
        slot     = active && (adr_hor[SCALE-1:0] == '0);
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter between VGA scan-out and a CPU port.
//   ckVideo, rstVideo_n       : pixel clock, async active-low reset
//   adrHor, adrVer            : scan coordinates (registered timing outputs)
//   flgActiveVideo, HS, VS    : active flag and syncs (syncs active low)
//   cpu                       : CPU request/ack port (slave side)
//   ramAdr, ramWe, ramDin     : RAM command, combinational from the grant
//   ramDout                   : RAM read data, one-cycle latency
//   rgbOut, HSout, VSout      : pixel and syncs, two cycles after the timing inputs
//   cntStall                  : saturating count of display-denied CPU cycles,
//                               cleared on the falling edge of VS
// The display owns every slot cycle; the CPU is served in any other cycle.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned SCALE = FB_SCALE,
    parameter int unsigned FB_W  = FB_WIDTH,
    parameter int unsigned FB_H  = FB_HEIGHT,
    parameter int unsigned AW    = FB_AW,
    parameter int unsigned DW    = FB_DW
) (
    input  logic            ckVideo,
    input  logic            rstVideo_n,
    input  logic [9:0]      adrHor,
    input  logic [9:0]      adrVer,
    input  logic            flgActiveVideo,
    input  logic            HS,
    input  logic            VS,
    vga_fb_arbiter_if.slave cpu,
    output logic [AW-1:0]   ramAdr,
    output logic            ramWe,
    output logic [DW-1:0]   ramDin,
    input  logic [DW-1:0]   ramDout,
    output logic [DW-1:0]   rgbOut,
    output logic            HSout,
    output logic            VSout,
    output logic [15:0]     cntStall
);

    localparam logic [AW:0] FB_PIXELS = (AW+1)'(FB_W * FB_H);

    cpu_state_t    state;
    logic          disp_slot;
    logic [AW-1:0] slot_adr;
    logic          in_range;
    logic          grant;
    logic          ack_q;
    logic          range_q;

    // Display pipeline registers
    logic          slot_d1;
    logic          act_d1;
    logic          hs_d1;
    logic          vs_d1;
    logic [DW-1:0] hold;

    vga_fb_addr_gen #(
        .SCALE (SCALE),
        .FB_W  (FB_W),
        .AW    (AW)
    ) u_addr_gen (
        .adr_hor  (adrHor),
        .adr_ver  (adrVer),
        .active   (flgActiveVideo),
        .slot     (disp_slot),
        .slot_adr (slot_adr)
    );

    always_comb begin
        in_range = {1'b0, cpu.adrCpu} < FB_PIXELS;
        grant    = (state == CPU_IDLE) && cpu.reqCpu && !disp_slot;

        ramAdr = '0;
        ramWe  = 1'b0;
        ramDin = '0;
        if (disp_slot) begin
            ramAdr = slot_adr;
        end else if (grant) begin
            ramAdr = cpu.adrCpu;
            ramWe  = cpu.weCpu && in_range;
            ramDin = cpu.datCpuW;
        end

        // RAM data only arrives during the ack cycle, so the read data is
        // gated straight from ramDout rather than registered a second time.
        cpu.ackCpu  = ack_q;
        cpu.datCpuR = (ack_q && range_q) ? ramDout : '0;
    end

    // CPU access FSM. A reset in the ACK state drops the pending ack.
    always_ff @(posedge ckVideo or negedge rstVideo_n) begin
        if (!rstVideo_n) begin
            state   <= CPU_IDLE;
            ack_q   <= 1'b0;
            range_q <= 1'b0;
        end else begin
            case (state)
                CPU_IDLE: begin
                    if (grant) begin
                        state   <= CPU_ACK;
                        ack_q   <= 1'b1;
                        range_q <= in_range;
                    end
                end
                CPU_ACK: begin
                    state <= CPU_IDLE;
                    ack_q <= 1'b0;
                end
                default: begin
                    state <= CPU_IDLE;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall counter: a VS falling edge clears it even if a denial happens
    // in the same cycle.
    always_ff @(posedge ckVideo or negedge rstVideo_n) begin
        if (!rstVideo_n) begin
            cntStall <= '0;
        end else if (vs_d1 && !VS) begin
            cntStall <= '0;
        end else if ((state == CPU_IDLE) && cpu.reqCpu && disp_slot && (cntStall != '1)) begin
            cntStall <= cntStall + 16'd1;
        end
    end

    // Two-stage display pipeline. The hold register keeps the last slot's
    // pixel, which repeats it across the remaining columns of the block.
    always_ff @(posedge ckVideo or negedge rstVideo_n) begin
        if (!rstVideo_n) begin
            slot_d1 <= 1'b0;
            act_d1  <= 1'b0;
            hs_d1   <= 1'b1;
            vs_d1   <= 1'b1;
            HSout   <= 1'b1;
            VSout   <= 1'b1;
            hold    <= '0;
            rgbOut  <= '0;
        end else begin
            slot_d1 <= disp_slot;
            act_d1  <= flgActiveVideo;
            hs_d1   <= HS;
            vs_d1   <= VS;
            HSout   <= hs_d1;
            VSout   <= vs_d1;
            if (slot_d1) begin
                hold <= ramDout;
            end
            rgbOut <= act_d1 ? (slot_d1 ? ramDout : hold) : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: drives scan coordinates directly,
// runs a CPU requester against a behavioural frame-buffer model and checks
// every cycle's RAM command, ack, read data, stall count and pixel output.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  adrHor = 10'd780;
    logic [9:0]  adrVer = 10'd500;
    logic        flgActiveVideo = 1'b0;
    logic        HS = 1'b1;
    logic        VS = 1'b1;
    logic [14:0] ramAdr;
    logic        ramWe;
    logic [11:0] ramDin;
    logic [11:0] ramDout;
    logic [11:0] rgbOut;
    logic        HSout;
    logic        VSout;
    logic [15:0] cntStall;

    vga_fb_arbiter_if #(.AW(15), .DW(12)) cpu_bus ();

    vga_fb_arbiter #(
        .SCALE (2),
        .FB_W  (160),
        .FB_H  (120),
        .AW    (15),
        .DW    (12)
    ) dut (
        .ckVideo        (clk),
        .rstVideo_n     (rst_n),
        .adrHor         (adrHor),
        .adrVer         (adrVer),
        .flgActiveVideo (flgActiveVideo),
        .HS             (HS),
        .VS             (VS),
        .cpu            (cpu_bus),
        .ramAdr         (ramAdr),
        .ramWe          (ramWe),
        .ramDin         (ramDin),
        .ramDout        (ramDout),
        .rgbOut         (rgbOut),
        .HSout          (HSout),
        .VSout          (VSout),
        .cntStall       (cntStall)
    );

    always #20 clk = ~clk;

    // Synchronous RAM, one-cycle read latency
    logic [11:0] mem [0:32767] = '{default: '0};
    always @(posedge clk) begin
        if (ramWe) mem[ramAdr] <= ramDin;
        ramDout <= mem[ramAdr];
    end

    typedef struct {
        logic        we;
        logic [14:0] a;
        logic [11:0] d;
    } op_t;

    typedef struct {
        pixel_t rgb;
        logic   hs;
        logic   vs;
        logic   act;
        int     h;
        int     v;
    } exp_t;

    // Reference model state
    pixel_t shadow [0:32767] = '{default: '0};
    pixel_t disp_word = '0;
    exp_t   dq[$];
    int     stall_m = 0;
    logic   prev_vs = 1'b1;
    logic   ack_now = 1'b0;

    // Requester state
    op_t    ops[$];
    logic   b2b = 1'b0;
    logic   hold_req = 1'b0;
    logic   gap_rand = 1'b0;
    int     gap_fix = 0;
    int     gap_cnt = 0;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc_n = 0;
    int     ack_cyc[$];
    pixel_t last_rd = '0;

    logic   reg_on = 1'b0;
    int     reg_h0 = 0;
    int     reg_v0 = 0;
    pixel_t reg_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put_op();
        cpu_bus.weCpu   = ops[0].we;
        cpu_bus.adrCpu  = ops[0].a;
        cpu_bus.datCpuW = ops[0].d;
        cpu_bus.reqCpu  = 1'b1;
    endtask

    task automatic kick();
        if (!cpu_bus.reqCpu && ops.size() > 0 && gap_cnt == 0) put_op();
    endtask

    // Requester: holds a request until acked, then either chains the next
    // one (b2b) or idles for a gap before the next request.
    task automatic cpu_drive();
        if (ack_now) begin
            void'(ops.pop_front());
            if (b2b && ops.size() > 0) begin
                put_op();
            end else begin
                cpu_bus.reqCpu = 1'b0;
                gap_cnt = gap_rand ? int'($urandom_range(0, 3)) : gap_fix;
            end
        end else if (!cpu_bus.reqCpu) begin
            if (gap_cnt > 0) gap_cnt--;
            else kick();
        end
    endtask

    task automatic model_reset();
        exp_t r;
        r = '{rgb: '0, hs: 1'b1, vs: 1'b1, act: 1'b0, h: 0, v: 0};
        dq.delete();
        dq.push_back(r);
        stall_m = 0;
        prev_vs = 1'b1;
        ack_now = 1'b0;
    endtask

    // One pixel clock: apply timing inputs, check the RAM command, advance,
    // then check everything registered by the DUT.
    task automatic cyc(input int hh, input int vv, input logic aa, input logic hhs, input logic vvs);
        logic   slot;
        logic   grant;
        logic   inr;
        logic   we_g;
        int     ca;
        int     sa;
        pixel_t rd_exp;
        exp_t   e;
        adrHor = 10'(hh);
        adrVer = 10'(vv);
        flgActiveVideo = aa;
        HS = hhs;
        VS = vvs;
        #1;
        slot  = aa && (hh % 4 == 0);
        grant = cpu_bus.reqCpu && !slot && !ack_now;
        ca    = int'(cpu_bus.adrCpu);
        inr   = (ca < 19200);
        we_g  = cpu_bus.weCpu;
        sa    = (vv / 4) * 160 + hh / 4;
        chk("ram_we", 32'(ramWe), 32'(grant && we_g && inr));
        if (slot) chk("slot_adr", 32'(ramAdr), 32'(sa));
        else if (grant) chk("cpu_adr", 32'(ramAdr), 32'(ca));
        if (grant && we_g) chk("ram_din", 32'(ramDin), 32'(cpu_bus.datCpuW));
        rd_exp = inr ? shadow[ca] : '0;
        if (grant && we_g && inr) shadow[ca] = cpu_bus.datCpuW;
        if (slot) disp_word = shadow[sa];
        e = '{rgb: (aa ? disp_word : '0), hs: hhs, vs: vvs, act: aa, h: hh, v: vv};
        dq.push_back(e);
        if (prev_vs && !vvs) stall_m = 0;
        else if (cpu_bus.reqCpu && slot && !ack_now && stall_m < 65535) stall_m++;
        prev_vs = vvs;

        @(posedge clk);
        #1;
        cyc_n++;
        chk("ack", 32'(cpu_bus.ackCpu), 32'(grant));
        if (grant && !we_g) begin
            chk("rd_data", 32'(cpu_bus.datCpuR), 32'(rd_exp));
            last_rd = cpu_bus.datCpuR;
        end
        chk("stall_cnt", 32'(cntStall), 32'(stall_m));
        if (dq.size() == 0) begin
            $display("FAIL pipe_model: observed empty expectation queue, required one entry");
            $fatal(1);
        end
        e = dq.pop_front();
        chk("rgb", 32'(rgbOut), 32'(e.rgb));
        chk("hs_out", 32'(HSout), 32'(e.hs));
        chk("vs_out", 32'(VSout), 32'(e.vs));
        if (reg_on && e.act && e.h >= reg_h0 && e.h < reg_h0 + 4 && e.v >= reg_v0 && e.v < reg_v0 + 4)
            chk("block_rgb", 32'(rgbOut), 32'(reg_val));
        ack_now = grant;
        if (grant) ack_cyc.push_back(cyc_n);
        if (!hold_req) cpu_drive();
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) cyc(780, 500, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic line(input int vl, input int h0, input int h1);
        for (int x = h0; x < h1; x++)
            cyc(x, vl, (x < 640 && vl < 480), !(x >= 656 && x < 752), 1'b1);
    endtask

    task automatic vs_fall();
        cyc(780, 500, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic add_op(input logic we, input int a, input int d);
        op_t o;
        o.we = we;
        o.a  = 15'(a);
        o.d  = 12'(d);
        ops.push_back(o);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1);
    end

    initial begin
        int acks0;
        int guard;
        cpu_bus.reqCpu  = 1'b0;
        cpu_bus.weCpu   = 1'b0;
        cpu_bus.adrCpu  = '0;
        cpu_bus.datCpuW = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #5;
        chk("rst_ack", 32'(cpu_bus.ackCpu), 32'(0));
        chk("rst_rdata", 32'(cpu_bus.datCpuR), 32'(0));
        chk("rst_rgb", 32'(rgbOut), 32'(0));
        chk("rst_hs", 32'(HSout), 32'(1));
        chk("rst_vs", 32'(VSout), 32'(1));
        chk("rst_stall", 32'(cntStall), 32'(0));
        rst_n = 1'b1;
        model_reset();
        blank(3);

        // Red block at the top-left corner, neighbours in other colours
        add_op(1'b1, 0, 'hF00);
        add_op(1'b1, 1, 'h0F0);
        add_op(1'b1, 160, 'h00F);
        kick();
        blank(12);
        reg_on = 1'b1; reg_h0 = 0; reg_v0 = 0; reg_val = 12'hF00;
        for (int vl = 0; vl < 6; vl++) begin
            line(vl, 0, 16);
            blank(3);
        end
        reg_on = 1'b0;

        // Requests at every display slot of one line: 160 denials
        vs_fall();
        blank(2);
        chk("stall_pre", 32'(cntStall), 32'(0));
        gap_fix = 1;
        for (int i = 0; i < 160; i++) add_op(1'b0, int'($urandom_range(0, 19199)), 0);
        kick();
        line(10, 0, 800);
        chk("stall_line", 32'(cntStall), 32'(160));
        vs_fall();
        chk("stall_clr", 32'(cntStall), 32'(0));
        gap_fix = 0;
        blank(4);

        // Last frame-buffer word
        add_op(1'b1, 19199, 'hABC);
        add_op(1'b0, 19199, 0);
        kick();
        blank(8);
        chk("rd_last", 32'(last_rd), 32'(12'hABC));
        reg_on = 1'b1; reg_h0 = 636; reg_v0 = 476; reg_val = 12'hABC;
        for (int vl = 476; vl < 480; vl++) begin
            line(vl, 628, 648);
            blank(2);
        end
        reg_on = 1'b0;

        // Out-of-range write is acked but suppressed; read returns 0
        acks0 = ack_cyc.size();
        add_op(1'b1, 19200, 'h123);
        add_op(1'b0, 19200, 0);
        kick();
        blank(8);
        chk("oor_acks", 32'(ack_cyc.size() - acks0), 32'(2));
        chk("oor_rd", 32'(last_rd), 32'(0));
        chk("oor_mem", 32'(mem[19200]), 32'(0));

        // Back-to-back reads with reqCpu held high
        ack_cyc.delete();
        b2b = 1'b1;
        for (int i = 0; i < 4; i++) add_op(1'b0, int'($urandom_range(0, 19199)), 0);
        kick();
        blank(12);
        b2b = 1'b0;
        chk("b2b_count", 32'(ack_cyc.size()), 32'(4));
        if (ack_cyc.size() >= 4)
            for (int i = 1; i < 4; i++)
                chk("b2b_period", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(2));

        // Reset while a read is in its ack cycle
        hold_req = 1'b1;
        add_op(1'b0, 1, 0);
        kick();
        cyc(780, 500, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(cpu_bus.ackCpu), 32'(0));
        chk("mid_rst_rgb", 32'(rgbOut), 32'(0));
        chk("mid_rst_hs", 32'(HSout), 32'(1));
        chk("mid_rst_vs", 32'(VSout), 32'(1));
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        model_reset();
        hold_req = 1'b0;
        acks0 = ack_cyc.size();
        blank(2);
        chk("rst_reack", 32'(ack_cyc.size() - acks0), 32'(1));
        chk("rst_rd", 32'(last_rd), 32'(12'h0F0));

        // Randomized traffic against random display segments
        gap_rand = 1'b1;
        for (int s = 0; s < 12; s++) begin
            int vl;
            int h0;
            for (int k = 0; k < 5; k++)
                add_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 21000)), int'($urandom));
            kick();
            vl = int'($urandom_range(0, 479));
            h0 = int'($urandom_range(0, 143)) * 4;
            line(vl, h0, h0 + 64);
            blank(8);
        end
        guard = 0;
        while (ops.size() > 0 && guard < 400) begin
            blank(1);
            guard++;
        end
        chk("drain", 32'(ops.size()), 32'(0));
        blank(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Single-port frame-buffer arbiter between the VGA scan-out and a CPU access port.
- Consumes the registered timing outputs of the VGA timing generator (pixel coordinates, active flag, syncs).
- Fetches scaled-down pixels from a synchronous RAM and re-aligns the syncs to the pixel data.
- Serves CPU read/write requests in cycles the display does not need.
- Display always has priority; the CPU is never granted a display slot.

Parameters:
- SCALE, 2, log2 of pixel replication factor (1 framebuffer pixel = 2^SCALE x 2^SCALE screen pixels)
- FB_W, 160, framebuffer width in pixels (640 >> SCALE)
- FB_H, 120, framebuffer height in lines (480 >> SCALE)
- AW, 15, RAM/CPU address width (must satisfy 2^AW >= FB_W*FB_H)
- DW, 12, pixel/data width (RGB 4:4:4)

Ports:
- ckVideo  in  1  pixel clock (25 MHz)
- rstVideo_n  in  1  asynchronous active-low reset
- adrHor  in  10  horizontal pixel counter from the timing generator
- adrVer  in  10  vertical line counter from the timing generator
- flgActiveVideo  in  1  active-video flag from the timing generator
- HS  in  1  horizontal sync from the timing generator (active low)
- VS  in  1  vertical sync from the timing generator (active low)
- reqCpu  in  1  CPU access request, held until ackCpu
- weCpu  in  1  1 = write, 0 = read; stable while reqCpu is high
- adrCpu  in  AW  CPU word address
- datCpuW  in  DW  CPU write data
- ackCpu  out  1  one-cycle completion pulse
- datCpuR  out  DW  CPU read data, valid while ackCpu is high
- ramAdr  out  AW  RAM address (combinational from the grant)
- ramWe  out  1  RAM write enable
- ramDin  out  DW  RAM write data
- ramDout  in  DW  RAM read data, one-cycle latency
- rgbOut  out  DW  pixel to the DAC; 0 outside active video
- HSout  out  1  HS delayed to align with rgbOut
- VSout  out  1  VS delayed to align with rgbOut
- cntStall  out  16  saturating count of cycles the CPU was denied by the display; cleared on the VS falling edge

Behaviour:
Reset values:
- ackCpu = 0, datCpuR = 0, rgbOut = 0, HSout = 1, VSout = 1, cntStall = 0.
- FSM in IDLE, pipeline valid bits cleared.
- Async reset mid-transaction aborts it: no ack is issued and the CPU must re-request.

Display slot:
- dispSlot = flgActiveVideo && adrHor[SCALE-1:0] == 0.
- Slot address = (adrVer >> SCALE) * FB_W + (adrHor >> SCALE), truncated to AW bits.
- In a slot: ramAdr = slot address, ramWe = 0.

Display pipeline (2-cycle latency):
- Cycle t: drive the RAM.
- Cycle t+1: ramDout is captured into the pixel hold register when the stage-1 slot bit is set.
- Cycle t+2: rgbOut = hold register if the delayed active flag is set, else 0.
- HS and VS pass through a 2-stage delay so HSout/VSout align with rgbOut.
- The hold register keeps its value between slots, which gives the horizontal replication.

CPU FSM (states IDLE, ACK):
- IDLE: if reqCpu && !dispSlot, drive ramAdr = adrCpu, ramWe = weCpu && inRange, ramDin = datCpuW, then go to ACK.
- IDLE: if reqCpu && dispSlot, stay in IDLE and increment cntStall (saturate at 0xFFFF).
- ACK: ackCpu = 1 for exactly one cycle. datCpuR = inRange ? ramDout : 0. reqCpu is ignored in this cycle. Next state is IDLE.
- Requester protocol: drop reqCpu the cycle after ackCpu, or keep it high to start a new request. Minimum CPU period is 2 cycles.
- inRange = adrCpu < FB_W*FB_H. Out-of-range writes are suppressed but still acked. Out-of-range reads return 0.

Contention rules:
- Display slot and CPU request in the same cycle: display wins, CPU waits.
- With SCALE=2 the CPU gets at least 3 of every 4 cycles in active video and every cycle in blanking.
- No outputs change while the RAM read of a CPU access is in flight, other than the pipeline.

Wrap-around:
- adrVer/adrHor beyond the active area are ignored via flgActiveVideo.
- cntStall clears on the VS falling edge; a clear takes priority over an increment in the same cycle.

Decomposition:
- Package vga_fb_pkg: VGA timing constants (640/16/96/48, 480/10/2/29), FB_W/FB_H/SCALE defaults, AW/DW, pixel typedef, FSM state enum.
- Sub-module vga_fb_addr_gen: combinational dispSlot and slot address computation (coordinate shift plus multiply-by-FB_W).

Test Plan:
- Reset asserted mid-read (reqCpu=1, weCpu=0, FSM in ACK): ackCpu stays 0, rgbOut=0, HSout=VSout=1; after release, the request completes with one ack 2 cycles later.
- CPU write adr 0x0000 = 0xF00, then screen pixels (0..3, 0..3) -> rgbOut = 0xF00 on those 16 pixels, 2 cycles after the timing inputs, with HSout/VSout aligned.
- CPU requests every cycle across an active line -> no grant when adrHor%4 == 0; 160 denials per line, so cntStall = 160 after one line; cntStall clears at VS fall.
- Write then read adr 19199 (last pixel) = 0xABC -> datCpuR = 0xABC with ackCpu; the pixel appears at screen (636..639, 476..479).
- Write adr 19200 (out of range) = 0x123 -> ackCpu pulses, ramWe stays 0; a read of adr 19200 returns 0.
- reqCpu held high for 4 back-to-back reads in blanking -> ackCpu on alternate cycles (period 2), 4 acks total.
